// File: rtl/zion_oh2bin_pkg.sv
// Shared types, constants and helpers for the onehot-to-binary stream encoder.
// Latency: none (package only).
// Backpressure: n/a.
package zion_oh2bin_pkg;

  // Width of the saturating error counter.
  localparam int ERR_CNT_W = 16;

  // Widest onehot vector the priority finder accepts; callers zero-extend.
  localparam int OH_MAX_W = 64;

  // Priority find-first-set: index of the lowest set bit, 0 when no bit is set.
  function automatic logic [31:0] oh_lowest_idx(input logic [OH_MAX_W-1:0] i_vec);
    oh_lowest_idx = '0;
    for (int k = OH_MAX_W - 1; k >= 0; k--) begin
      if (i_vec[k]) oh_lowest_idx = 32'(k);
    end
  endfunction

endpackage

// File: rtl/zion_oh2bin_stream_enc_if.sv
// Valid/ready bundle for the onehot-to-binary stream encoder (input and output sides).
// Latency: none (wiring only).
// Backpressure: iRdy/oRdy carried as plain handshake wires.
interface zion_oh2bin_stream_enc_if
  import zion_oh2bin_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 4
);
  logic                 iVld;
  logic                 iRdy;
  logic [WIDTH_IN-1:0]  iDat;
  logic                 oVld;
  logic                 oRdy;
  logic [WIDTH_OUT-1:0] oDat;
  logic                 oErr;

  // Producer/consumer side (drives the encoder).
  modport master (output iVld, iDat, oRdy, input iRdy, oVld, oDat, oErr);
  // Encoder side.
  modport slave  (input iVld, iDat, oRdy, output iRdy, oVld, oDat, oErr);
endinterface

// File: rtl/zion_skid_buf2.sv
// Generic 2-entry valid/ready buffer with registered head and ready.
// Latency: 1 cycle from push into an empty buffer to o_pop_vld.
// Backpressure: o_push_rdy depends only on the stored count, never on i_pop_rdy.
module zion_skid_buf2
  import zion_oh2bin_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_vld,
  output logic         o_push_rdy,
  input  logic [W-1:0] i_push_dat,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy,
  output logic [W-1:0] o_pop_dat
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_push_rdy = (r_cnt != 2'd2);
  assign o_pop_vld  = (r_cnt != 2'd0);
  assign w_push     = i_push_vld & o_push_rdy;
  assign w_pop      = o_pop_vld & i_pop_rdy;
  assign o_pop_dat  = r_mem[r_rptr];

  // Storage, 1-bit wrapping pointers and occupancy; a concurrent push lands behind the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) r_mem[k] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/zion_oh2bin_stream_enc.sv
// Streaming onehot-to-binary encoder: oDat = START + idx*STEP, oErr flags zero/multi-hot.
// Latency: 1 cycle from accepted input to oVld; optional error counter via ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN.
// Backpressure: 2-entry buffer; iRdy is registered state only, no combinational path from oRdy.
module zion_oh2bin_stream_enc
  import zion_oh2bin_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 4,
  parameter int START     = 0,
  parameter int STEP      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]   oErrCnt,
`endif
  zion_oh2bin_stream_enc_if.slave bus
);
  typedef struct packed {
    logic                 err;
    logic [WIDTH_OUT-1:0] dat;
  } oh2bin_ent_t;

  localparam int ENT_W = $bits(oh2bin_ent_t);

  logic [OH_MAX_W-1:0] w_vec;
  logic [31:0]         w_idx;
  logic [31:0]         w_enc32;
  logic                w_zero;
  logic                w_multi;
  oh2bin_ent_t         w_ent;
  oh2bin_ent_t         w_head;

  // Elaboration-time sanity of the code mapping; ignored by synthesis.
  initial begin : p_param_chk
    if (longint'(START) + longint'(WIDTH_IN - 1) * longint'(STEP) > (longint'(1) << WIDTH_OUT) - 1) begin
      $error("zion_oh2bin_stream_enc: highest code does not fit in WIDTH_OUT");
`ifdef CHECK_ERR_EXIT
      $finish;
`endif
    end
    if (STEP < 1) begin
      $error("zion_oh2bin_stream_enc: STEP must be >= 1");
`ifdef CHECK_ERR_EXIT
      $finish;
`endif
    end
  end

  // Encode ahead of the buffer: lowest set bit wins, zero-hot maps to START.
  always_comb begin
    w_vec     = OH_MAX_W'(bus.iDat);
    w_idx     = oh_lowest_idx(w_vec);
    w_enc32   = 32'(START) + w_idx * 32'(STEP);
    w_zero    = (w_vec == '0);
    w_multi   = ((w_vec & (w_vec - OH_MAX_W'(1))) != '0);
    w_ent     = '0;
    w_ent.dat = WIDTH_OUT'(w_enc32);
    w_ent.err = w_zero | w_multi;
  end

  zion_skid_buf2 #(.W(ENT_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (bus.iVld),
    .o_push_rdy (bus.iRdy),
    .i_push_dat (w_ent),
    .o_pop_vld  (bus.oVld),
    .i_pop_rdy  (bus.oRdy),
    .o_pop_dat  (w_head)
  );

  assign bus.oDat = w_head.dat;
  assign bus.oErr = w_head.err;

`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
  logic                 w_push;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_push  = bus.iVld & bus.iRdy;
  assign oErrCnt = r_err_cnt;

  // Count accepted bad vectors, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_push && w_ent.err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_zion_oh2bin_stream_enc.sv
// Self-checking bench: vector table, directed corner sequences, random traffic vs queue model.
// Latency: model expects head visible 1 cycle after push into empty buffer.
// Backpressure: model tracks occupancy as queue size (max 2).
module tb_zion_oh2bin_stream_enc;
  import zion_oh2bin_pkg::*;

  localparam int WI  = 8;
  localparam int WO  = 4;
  localparam int ST0 = 0;
  localparam int SP0 = 1;
  localparam int WO1 = 5;
  localparam int ST1 = 2;
  localparam int SP1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zion_oh2bin_stream_enc_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO))  b0 ();
  zion_oh2bin_stream_enc_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO1)) b1 ();

`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  zion_oh2bin_stream_enc #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .START(ST0), .STEP(SP0)) u0 (
    .clk (clk),
    .rst (rst),
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
    .oErrCnt (cnt0),
`endif
    .bus (b0)
  );

  zion_oh2bin_stream_enc #(.WIDTH_IN(WI), .WIDTH_OUT(WO1), .START(ST1), .STEP(SP1)) u1 (
    .clk (clk),
    .rst (rst),
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
    .oErrCnt (cnt1),
`endif
    .bus (b1)
  );

  typedef struct {
    logic [WO-1:0] dat;
    logic          err;
  } ent_t;

  typedef struct {
    logic [7:0] din;
    logic [4:0] dat;
    logic       err;
    bit         dut1;
  } vec_t;

  ent_t        mq[$];
  int unsigned m_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the mapping rule.
  function automatic int ref_dat(input logic [WI-1:0] v, input int start, input int step, input int wo);
    int idx;
    idx = 0;
    for (int k = WI - 1; k >= 0; k--) if (v[k]) idx = k;
    return (start + idx * step) % (1 << wo);
  endfunction

  function automatic logic ref_err(input logic [WI-1:0] v);
    return ($countones(v) != 1);
  endfunction

  // One clock on u0 with the queue model updated from pre-edge inputs, then compared.
  task automatic cycle();
    logic r;
    logic push;
    logic pop;
    ent_t e;
    r     = rst;
    push  = b0.iVld && (mq.size() != 2);
    pop   = (mq.size() != 0) && b0.oRdy;
    e.dat = WO'(ref_dat(b0.iDat, ST0, SP0, WO));
    e.err = ref_err(b0.iDat);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (e.err && m_cnt != 32'hFFFF) m_cnt++;
      end
    end
    #1;
    chk("model_oVld", 32'(b0.oVld), 32'(mq.size() != 0));
    chk("model_iRdy", 32'(b0.iRdy), 32'(mq.size() != 2));
    if (mq.size() != 0) begin
      chk("model_oDat", 32'(b0.oDat), 32'(mq[0].dat));
      chk("model_oErr", 32'(b0.oErr), 32'(mq[0].err));
    end
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
    chk("model_oErrCnt", 32'(cnt0), m_cnt);
`endif
  endtask

  vec_t tv[$];

  initial begin
    int nerr0;
    int nerr1;

    tv.push_back('{8'h10, 5'd4,  1'b0, 1'b0});
    tv.push_back('{8'h00, 5'd0,  1'b1, 1'b0});
    tv.push_back('{8'h24, 5'd2,  1'b1, 1'b0});
    tv.push_back('{8'h01, 5'd0,  1'b0, 1'b0});
    tv.push_back('{8'h80, 5'd7,  1'b0, 1'b0});
    tv.push_back('{8'hFF, 5'd0,  1'b1, 1'b0});
    tv.push_back('{8'hC0, 5'd6,  1'b1, 1'b0});
    tv.push_back('{8'h80, 5'd23, 1'b0, 1'b1});
    tv.push_back('{8'h01, 5'd2,  1'b0, 1'b1});
    tv.push_back('{8'h00, 5'd2,  1'b1, 1'b1});
    tv.push_back('{8'h0C, 5'd8,  1'b1, 1'b1});
    tv.push_back('{8'h10, 5'd14, 1'b0, 1'b1});

    rst = 1'b1;
    b0.iVld = 1'b0; b0.iDat = '0; b0.oRdy = 1'b0;
    b1.iVld = 1'b0; b1.iDat = '0; b1.oRdy = 1'b0;
    cycle();
    cycle();
    chk("rst_oVld", 32'(b0.oVld), 32'd0);
    chk("rst_iRdy", 32'(b0.iRdy), 32'd1);
    chk("rst_oDat", 32'(b0.oDat), 32'd0);
    chk("rst_oErr", 32'(b0.oErr), 32'd0);
    chk("rst_u1_oVld", 32'(b1.oVld), 32'd0);
    chk("rst_u1_iRdy", 32'(b1.iRdy), 32'd1);
    rst = 1'b0;
    cycle();

    // Table vectors: push one, check the head one cycle later, then drain.
    nerr0 = 0;
    nerr1 = 0;
    foreach (tv[i]) begin
      if (!tv[i].dut1) begin
        if (tv[i].err) nerr0++;
        b0.iVld = 1'b1; b0.iDat = tv[i].din; b0.oRdy = 1'b1;
        cycle();
        b0.iVld = 1'b0;
        chk("tv_oVld", 32'(b0.oVld), 32'd1);
        chk("tv_oDat", 32'(b0.oDat), 32'(tv[i].dat));
        chk("tv_oErr", 32'(b0.oErr), 32'(tv[i].err));
        cycle();
      end else begin
        if (tv[i].err) nerr1++;
        b1.iVld = 1'b1; b1.iDat = tv[i].din; b1.oRdy = 1'b1;
        cycle();
        b1.iVld = 1'b0;
        chk("tv1_oVld", 32'(b1.oVld), 32'd1);
        chk("tv1_oDat", 32'(b1.oDat), 32'(tv[i].dat));
        chk("tv1_oErr", 32'(b1.oErr), 32'(tv[i].err));
        cycle();
        chk("tv1_drain", 32'(b1.oVld), 32'd0);
      end
    end
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
    chk("errcnt_u0", 32'(cnt0), 32'(nerr0));
    chk("errcnt_u1", 32'(cnt1), 32'(nerr1));
`endif

    // Backpressure: fill, stall a third item, then release in order.
    b0.oRdy = 1'b0;
    b0.iVld = 1'b1; b0.iDat = 8'h01;
    cycle();
    b0.iDat = 8'h02;
    cycle();
    chk("bp_full_iRdy", 32'(b0.iRdy), 32'd0);
    b0.iDat = 8'h04;
    repeat (3) begin
      cycle();
      chk("bp_hold_oVld", 32'(b0.oVld), 32'd1);
      chk("bp_hold_oDat", 32'(b0.oDat), 32'd0);
    end
    b0.oRdy = 1'b1;
    cycle();
    chk("bp_pop1_iRdy", 32'(b0.iRdy), 32'd1);
    chk("bp_pop1_oDat", 32'(b0.oDat), 32'd1);
    cycle();
    b0.iVld = 1'b0;
    chk("bp_pop2_oDat", 32'(b0.oDat), 32'd2);
    cycle();
    chk("bp_empty", 32'(b0.oVld), 32'd0);

    // Streaming at count 1: one output per cycle.
    b0.oRdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b0.iVld = 1'b1;
      b0.iDat = 8'(1 << k);
      cycle();
      chk("stream_oVld", 32'(b0.oVld), 32'd1);
      chk("stream_oDat", 32'(b0.oDat), 32'(k));
      chk("stream_iRdy", 32'(b0.iRdy), 32'd1);
    end
    b0.iVld = 1'b0;
    cycle();

    // Reset with a full buffer: nothing buffered may appear afterwards.
    b0.oRdy = 1'b0;
    b0.iVld = 1'b1; b0.iDat = 8'h10;
    cycle();
    b0.iDat = 8'h20;
    cycle();
    chk("rstmid_full", 32'(b0.iRdy), 32'd0);
    b0.iVld = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rstmid_oVld", 32'(b0.oVld), 32'd0);
    chk("rstmid_iRdy", 32'(b0.iRdy), 32'd1);
`ifdef ZION_OH2BIN_STREAM_ENC_ERR_CNT_EN
    chk("rstmid_cnt", 32'(cnt0), 32'd0);
`endif
    b0.oRdy = 1'b1;
    repeat (3) begin
      cycle();
      chk("rstmid_noout", 32'(b0.oVld), 32'd0);
    end

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      b0.iVld = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       b0.iDat = '0;
        1:       b0.iDat = 8'($urandom);
        default: b0.iDat = 8'(1 << $urandom_range(0, 7));
      endcase
      if (n < 1000) b0.oRdy = ($urandom_range(0, 3) == 0);
      else          b0.oRdy = ($urandom_range(0, 2) != 0);
      cycle();
    end
    b0.iVld = 1'b0;
    b0.oRdy = 1'b1;
    repeat (3) cycle();
    chk("final_empty", 32'(b0.oVld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
